button_pio_in: RTL and testbench



---
 rtl/button_pio_pkg.sv | 26 ++
 rtl/pio_debounce.sv | 78 +++++++
 rtl/button_pio_in.sv | 97 +++++++++
 tb/tb_button_pio_in.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pio_pkg.sv
// Shared constants for the button/switch input PIO: register addresses,
// edge-type encodings and the edge qualification helper.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when a debounced level change away from old_level is one we capture.
  function automatic logic edge_match(input int edge_type, input logic old_level);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = ~old_level;
      EDGE_FALL: hit = old_level;
      EDGE_ANY:  hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: 2-flop synchronizer followed by a
// stable-count debouncer. change pulses on the clock where stable flips.
module pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic change
);

  logic s1_r;
  logic s2_r;
  logic stable_r;
  logic change_s;

  // Two-stage synchronizer for the asynchronous board pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= IDLE_BIT;
      s2_r <= IDLE_BIT;
    end else begin
      s1_r <= pin;
      s2_r <= s1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: the accepted level follows the synchronizer.
      always_comb begin
        change_s = (s2_r != stable_r);
      end

      // Accepted level register, updated every clock.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable_r <= IDLE_BIT;
        end else begin
          stable_r <= s2_r;
        end
      end
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count_r;
      logic          differ_s;

      // A level is accepted once it has differed for DEBOUNCE_CYCLES clocks.
      always_comb begin
        differ_s = (s2_r != stable_r);
        change_s = differ_s && (count_r == LAST);
      end

      // Stability counter; any return to the accepted level restarts it.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_r  <= {CW{1'b0}};
          stable_r <= IDLE_BIT;
        end else if (!differ_s) begin
          count_r  <= {CW{1'b0}};
        end else if (count_r == LAST) begin
          stable_r <= s2_r;
          count_r  <= {CW{1'b0}};
        end else begin
          count_r  <= count_r + CW'(1);
        end
      end
    end
  endgenerate

  assign stable = stable_r;
  assign change = change_s;

endmodule

// File: rtl/button_pio_in.sv
// Avalon-MM input PIO for buttons and DIP switches: debounced pin state,
// write-1-to-clear edge capture, masked level interrupt.
module button_pio_in
  import button_pio_pkg::*;
#(
  parameter int             WIDTH           = 4,
  parameter int             DEBOUNCE_CYCLES = 50000,
  parameter int             EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] change_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_next_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edge_r;
  logic             irq_r;
  logic             wr_s;
  logic [31:0]      readdata_s;
  logic             unused_wdata_s;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_BIT       (IDLE_LEVEL[i])
      ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .pin   (in_port[i]),
        .stable(stable_s[i]),
        .change(change_s[i])
      );
    end
  endgenerate

  // Upper write-data bits beyond WIDTH carry no meaning.
  assign unused_wdata_s = &{1'b0, writedata};

  // Edge set/clear terms; a capture in the same clock as a W1C wins.
  always_comb begin
    wr_s  = chipselect && !write_n;
    set_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      set_s[i] = change_s[i] && edge_match(EDGE_TYPE, stable_s[i]);
    end
    if (wr_s && (address == ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    edge_next_s = (edge_r & ~clr_s) | set_s;
  end

  // Mask, edge-capture and registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r <= {WIDTH{1'b0}};
      edge_r <= {WIDTH{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      edge_r <= edge_next_s;
      if (wr_s && (address == ADDR_MASK)) begin
        mask_r <= writedata[WIDTH-1:0];
      end
      irq_r  <= |(edge_r & mask_r);
    end
  end

  // Zero-wait read mux, zero-extended, no side effects.
  always_comb begin
    readdata_s = 32'd0;
    case (address)
      ADDR_DATA: readdata_s[WIDTH-1:0] = stable_s;
      ADDR_RSVD: readdata_s = 32'd0;
      ADDR_MASK: readdata_s[WIDTH-1:0] = mask_r;
      ADDR_EDGE: readdata_s[WIDTH-1:0] = edge_r;
      default:   readdata_s = 32'd0;
    endcase
  end

  assign readdata = readdata_s;
  assign irq      = irq_r;

endmodule

// File: tb/tb_button_pio_in.sv
// Self-checking bench for button_pio_in (WIDTH=4, DEBOUNCE_CYCLES=4).
// A second instance with EDGE_TYPE=2 shares all inputs.
module tb_button_pio_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_port = 4'hF;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic        irq;
  logic        irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)) dut (
    .clk(clk), .reset(reset), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  button_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF)) dut_any (
    .clk(clk), .reset(reset), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata2), .irq(irq2)
  );

  typedef struct {
    string       name;
    logic [3:0]  pins;
    logic        cs;
    logic        wn;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          cycles;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d2);
    address = a;
    #1;
    d  = readdata;
    d2 = readdata2;
  endtask

  logic [31:0] r;
  logic [31:0] r2;
  logic        seen;

  initial begin
    // name, pins, cs, wn, waddr, wdata, cycles, raddr, exp_rd, exp_irq
    vecs.push_back('{"press_early",   4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        5, 2'd0, 32'hF, 1'b0});
    vecs.push_back('{"press_data",    4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd0, 32'hE, 1'b0});
    vecs.push_back('{"press_edge",    4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd3, 32'h1, 1'b0});
    vecs.push_back('{"w1c_clear",     4'hE, 1'b1, 1'b0, 2'd3, 32'h1,        1, 2'd3, 32'h0, 1'b0});
    vecs.push_back('{"mask_write",    4'hE, 1'b1, 1'b0, 2'd2, 32'h1,        1, 2'd2, 32'h1, 1'b0});
    vecs.push_back('{"mask_hold",     4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd2, 32'h1, 1'b0});
    vecs.push_back('{"release_data",  4'hF, 1'b0, 1'b1, 2'd0, 32'h0,        6, 2'd0, 32'hF, 1'b0});
    vecs.push_back('{"release_noedg", 4'hF, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd3, 32'h0, 1'b0});
    vecs.push_back('{"press2_edge",   4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        6, 2'd3, 32'h1, 1'b0});
    vecs.push_back('{"press2_irq",    4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd3, 32'h1, 1'b1});
    vecs.push_back('{"irq_w1c",       4'hE, 1'b1, 1'b0, 2'd3, 32'h1,        1, 2'd3, 32'h0, 1'b1});
    vecs.push_back('{"irq_drop",      4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd3, 32'h0, 1'b0});
    vecs.push_back('{"rsvd_write",    4'hE, 1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 1, 2'd1, 32'h0, 1'b0});
    vecs.push_back('{"release2",      4'hF, 1'b0, 1'b1, 2'd0, 32'h0,        7, 2'd0, 32'hF, 1'b0});
    vecs.push_back('{"release2_edg",  4'hF, 1'b0, 1'b1, 2'd0, 32'h0,        1, 2'd3, 32'h0, 1'b0});
    vecs.push_back('{"mask_trunc",    4'hF, 1'b1, 1'b0, 2'd2, 32'hFFFFFFF5, 1, 2'd2, 32'h5, 1'b0});
    vecs.push_back('{"no_cs",         4'hF, 1'b0, 1'b0, 2'd2, 32'hF,        1, 2'd2, 32'h5, 1'b0});
    vecs.push_back('{"no_wr",         4'hF, 1'b1, 1'b1, 2'd2, 32'h0,        1, 2'd2, 32'h5, 1'b0});
    vecs.push_back('{"mask_zero",     4'hF, 1'b1, 1'b0, 2'd2, 32'h0,        1, 2'd2, 32'h0, 1'b0});
    vecs.push_back('{"data_ro",       4'hF, 1'b1, 1'b0, 2'd0, 32'h0,        1, 2'd0, 32'hF, 1'b0});

    // Reset, then idle pins for 20 clocks.
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      rd(2'd0, r, r2);
      check("rst_data", r, 32'hF);
      rd(2'd3, r, r2);
      check("rst_edge", r, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'd0);
    end

    // Table-driven vectors.
    for (int v = 0; v < vecs.size(); v++) begin
      in_port    = vecs[v].pins;
      chipselect = vecs[v].cs;
      write_n    = vecs[v].wn;
      address    = vecs[v].waddr;
      writedata  = vecs[v].wdata;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      if (vecs[v].cycles > 1) step(vecs[v].cycles - 1);
      rd(vecs[v].raddr, r, r2);
      check({vecs[v].name, "_rd"}, r, vecs[v].exp_rd);
      check({vecs[v].name, "_irq"}, {31'd0, irq}, {31'd0, vecs[v].exp_irq});
    end

    // 3-cycle glitch on bit 2 is rejected.
    in_port = 4'hB;
    step(3);
    in_port = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step(1);
      rd(2'd0, r, r2);
      check("glitch3_data", r, 32'hF);
    end
    rd(2'd3, r, r2);
    check("glitch3_edge", r, 32'h0);

    // 4-cycle pulse on bit 2 is accepted.
    in_port = 4'hB;
    step(4);
    in_port = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      rd(2'd0, r, r2);
      if (r == 32'hB) seen = 1'b1;
    end
    check("pulse4_seen", {31'd0, seen}, 32'd1);
    rd(2'd3, r, r2);
    check("pulse4_edge", r, 32'h4);
    bus_write(2'd3, 32'hF);
    rd(2'd3, r, r2);
    check("pulse4_clr", r, 32'h0);

    // W1C in the same clock bit 1 captures: set wins.
    in_port = 4'hD;
    step(5);
    bus_write(2'd3, 32'h2);
    rd(2'd3, r, r2);
    check("collide_edge", r, 32'h2);
    rd(2'd0, r, r2);
    check("collide_data", r, 32'hD);
    in_port = 4'hF;
    step(7);
    bus_write(2'd3, 32'hF);
    rd(2'd3, r, r2);
    check("collide_clr", r, 32'h0);

    // Reset during a debounce count with bit 3 held low.
    in_port = 4'h7;
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      rd(2'd0, r, r2);
      check("rstmid_data", r, (k < 6) ? 32'hF : 32'h7);
      rd(2'd3, r, r2);
      check("rstmid_edge", r, (k < 6) ? 32'h0 : 32'h8);
      check("rstmid_irq", {31'd0, irq}, 32'd0);
    end

    // Any-edge instance captures both press and release.
    bus_write(2'd3, 32'hF);
    rd(2'd3, r, r2);
    check("any_clr", r2, 32'h0);
    in_port = 4'hF;
    step(7);
    rd(2'd3, r, r2);
    check("rel_fall_inst", r, 32'h0);
    check("rel_any_inst", r2, 32'h8);
    bus_write(2'd3, 32'hF);
    in_port = 4'h7;
    step(7);
    rd(2'd3, r, r2);
    check("press_fall_inst", r, 32'h8);
    check("press_any_inst", r2, 32'h8);
    rd(2'd0, r, r2);
    check("any_data", r2, 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
